// File: rtl/alu_cmd_issue.sv
// Issue/writeback stage around the external 4-bit signed ALU.
// Commands queue in a FIFO; the head feeds the ALU and the result is registered.
module alu_cmd_issue #(
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opt,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic [2:0]       alu_opt,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [3:0]       alu_result,
    input  logic             alu_less,
    input  logic             alu_equal,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_opt,
    output logic [3:0]       out_result,
    output logic [4:0]       out_flags,
    output logic [PTR_W:0]   fifo_count,
    output logic [7:0]       op_count
);

    typedef struct packed {
        logic [2:0] opt;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    cmd_t             mem [FIFO_DEPTH];
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             not_empty;
    logic             out_free;
    logic             push;
    logic             pop;
    logic             deliver;

    assign not_empty = (fifo_count != '0);
    assign in_ready  = (fifo_count != FULL_CNT);
    assign out_free  = ~out_valid | out_ready;
    assign push      = in_valid & in_ready;
    assign pop       = not_empty & out_free;
    assign deliver   = out_valid & out_ready;

    // An empty FIFO presents zeros so the ALU sees a quiet input.
    always_comb begin
        head = '0;
        if (not_empty) begin
            head = mem[rd_ptr];
        end
    end

    assign alu_opt = head.opt;
    assign alu_a   = head.a;
    assign alu_b   = head.b;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{opt: in_opt, a: in_a, b: in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            out_valid  <= 1'b0;
            out_opt    <= '0;
            out_result <= '0;
            out_flags  <= '0;
            op_count   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            // Result register holds while the consumer stalls.
            if (pop) begin
                out_valid  <= 1'b1;
                out_opt    <= alu_opt;
                out_result <= alu_result;
                out_flags  <= {alu_less, alu_equal, alu_carry,
                               alu_overflow, alu_zero};
            end else if (deliver) begin
                out_valid <= 1'b0;
            end
            if (deliver) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule
